// File: rtl/fir_pkg.sv
// Definitions shared between the FIR stage and the downstream frame accumulator.
package fir_pkg;

  localparam int DATA_W = 8;
  localparam int NIB_W  = 4;
  localparam int WRAP_W = 2 * NIB_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    ACC
  } acc_state_t;

  // Wide enough that FRAME_LEN full-scale samples can never overflow.
  function automatic int sum_width(input int frame_len);
    return DATA_W + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/fir_res_slot.sv
// Single-entry result holding register with valid/ready handshake and sticky overrun flag.
module fir_res_slot
  import fir_pkg::*;
#(
  parameter int SUM_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_ovr_i,
  input  logic              load_i,
  input  logic [SUM_W-1:0]  sum_i,
  input  logic [DATA_W-1:0] min_i,
  input  logic [DATA_W-1:0] max_i,
  input  logic [WRAP_W-1:0] wrap_i,
  input  logic              res_ready_i,
  output logic              res_valid_o,
  output logic [SUM_W-1:0]  sum_o,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o,
  output logic [WRAP_W-1:0] wrap_o,
  output logic              overrun_o
);

  logic              valid_q;
  logic [SUM_W-1:0]  sum_q;
  logic [DATA_W-1:0] min_q;
  logic [DATA_W-1:0] max_q;
  logic [WRAP_W-1:0] wrap_q;
  logic              ovr_q;

  // A new frame may only replace the held one if the slot is empty or being read now.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      wrap_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (load_i) begin
        if (!valid_q || res_ready_i) begin
          valid_q <= 1'b1;
          sum_q   <= sum_i;
          min_q   <= min_i;
          max_q   <= max_i;
          wrap_q  <= wrap_i;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && res_ready_i) begin
        valid_q <= 1'b0;
      end
      if (clr_ovr_i) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign res_valid_o = valid_q;
  assign sum_o       = sum_q;
  assign min_o       = min_q;
  assign max_o       = max_q;
  assign wrap_o      = wrap_q;
  assign overrun_o   = ovr_q;

endmodule

// File: rtl/fir_frame_acc.sv
// Frame statistics accumulator: skips the FIR pipeline fill after start, then
// reports sum/min/max/wrap count of every FRAME_LEN-sample frame.
module fir_frame_acc
  import fir_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  parameter  int SKIP      = 8,
  localparam int SUM_W     = sum_width(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [SUM_W-1:0]  sum_o,
  output logic [DATA_W-1:0] min_o,
  output logic [DATA_W-1:0] max_o,
  output logic [WRAP_W-1:0] wrap_o,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int              CNT_W       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(FRAME_LEN - 1);
  localparam logic [7:0]       LAST_FILL   = 8'(SKIP - 1);

  acc_state_t        state_q;
  logic [7:0]        fillCnt_q;
  logic [CNT_W-1:0]  sampCnt_q;
  logic              busy_q;

  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic [DATA_W-1:0] prev_q, prev_d;

  logic              inAcc;
  logic              firstSample;
  logic              frameDone;
  logic [SUM_W-1:0]  sumNext;
  logic [DATA_W-1:0] minNext;
  logic [DATA_W-1:0] maxNext;
  logic [WRAP_W-1:0] wrapNext;

  // A start pulse overrides everything, including a frame that would complete this cycle.
  assign inAcc       = (state_q == ACC) && !start_i;
  assign firstSample = (sampCnt_q == '0);
  assign frameDone   = inAcc && (sampCnt_q == LAST_SAMPLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fillCnt_q <= '0;
      sampCnt_q <= '0;
      busy_q    <= 1'b0;
    end else if (start_i) begin
      state_q   <= FILL;
      fillCnt_q <= '0;
      sampCnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        FILL: begin
          if (fillCnt_q == LAST_FILL) begin
            state_q   <= ACC;
            sampCnt_q <= '0;
          end else begin
            fillCnt_q <= fillCnt_q + 8'd1;
          end
        end
        ACC: begin
          sampCnt_q <= frameDone ? '0 : sampCnt_q + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Running stats including the current sample; these feed both the accumulators and the result slot.
  always_comb begin
    sumNext  = acc_q + SUM_W'(din_i);
    minNext  = (firstSample || (din_i < min_q)) ? din_i : min_q;
    maxNext  = (firstSample || (din_i > max_q)) ? din_i : max_q;
    wrapNext = wrap_q;
    if (!firstSample && (din_i < prev_q) && (wrap_q != '1)) begin
      wrapNext = wrap_q + WRAP_W'(1);
    end
  end

  always_comb begin
    acc_d  = acc_q;
    min_d  = min_q;
    max_d  = max_q;
    wrap_d = wrap_q;
    prev_d = prev_q;
    if (start_i) begin
      acc_d  = '0;
      min_d  = '0;
      max_d  = '0;
      wrap_d = '0;
    end else if (inAcc) begin
      prev_d = din_i;
      if (frameDone) begin
        acc_d  = '0;
        min_d  = '0;
        max_d  = '0;
        wrap_d = '0;
      end else begin
        acc_d  = sumNext;
        min_d  = minNext;
        max_d  = maxNext;
        wrap_d = wrapNext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      min_q  <= '0;
      max_q  <= '0;
      wrap_q <= '0;
      prev_q <= '0;
    end else begin
      acc_q  <= acc_d;
      min_q  <= min_d;
      max_q  <= max_d;
      wrap_q <= wrap_d;
      prev_q <= prev_d;
    end
  end

  fir_res_slot #(
    .SUM_W(SUM_W)
  ) u_res_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_ovr_i  (start_i),
    .load_i     (frameDone),
    .sum_i      (sumNext),
    .min_i      (minNext),
    .max_i      (maxNext),
    .wrap_i     (wrapNext),
    .res_ready_i(res_ready_i),
    .res_valid_o(res_valid_o),
    .sum_o      (sum_o),
    .min_o      (min_o),
    .max_o      (max_o),
    .wrap_o     (wrap_o),
    .overrun_o  (overrun_o)
  );

  assign busy_o = busy_q;

endmodule
